// File: rtl/valu_pkg.sv
// Shared widths and types for the 4x8-bit vector ALU and its requant/pack producer.
package valu_pkg;

  localparam int LANES   = 4;
  localparam int LANE_W  = 8;
  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 5;

  typedef logic [LANES-1:0][LANE_W-1:0] packed_word_t;
  typedef logic [$clog2(LANES)-1:0]     lane_cnt_t;

  // Byte-enable mask with the lowest n lanes set.
  function automatic logic [LANES-1:0] lane_mask(lane_cnt_t n);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      if (i < int'(n)) lane_mask[i] = 1'b1;
  endfunction

endpackage

// File: rtl/vrequant_lane.sv
// Combinational requant of one accumulator: rounding arithmetic shift, ReLU, saturate to u8.
module vrequant_lane
  import valu_pkg::*;
(
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [LANE_W-1:0]  res,
  output logic               sat
);

  // One guard bit so acc + half-LSB cannot wrap at the positive limit.
  logic signed [ACC_W:0] ext, rnd, r;

  always_comb begin
    ext = {acc[ACC_W-1], acc};
    rnd = '0;
    if (shift != '0) rnd = (ACC_W+1)'(1) << (shift - 1'b1);
    r   = (ext + rnd) >>> shift;
    sat = 1'b0;
    if (r[ACC_W]) begin
      res = '0;
    end else if (r > (ACC_W+1)'(255)) begin
      res = '1;
      sat = 1'b1;
    end else begin
      res = r[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/vpack_requant.sv
// Requantizes a stream of 32-bit accumulators to u8 and packs four per output word, with flush.
module vpack_requant
  import valu_pkg::*;
#(
  parameter int unsigned CVA6Cfg = 0,  // core configuration, not used internally
  parameter int unsigned LANES   = 4   // must match valu_pkg::LANES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] acc_i,
  input  logic [4:0]  shift_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  output logic [31:0] word_o,
  output logic [3:0]  byte_en_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sat_o,
  input  logic        clr_sat_i
);

  localparam lane_cnt_t LANE_LAST = lane_cnt_t'(LANES - 1);

  logic unused_cfg;
  assign unused_cfg = ^CVA6Cfg;

  lane_cnt_t    count, cnt_nxt;
  packed_word_t pack_q, pack_nxt;
  logic         flush_pend;
  logic [7:0]   lane_byte;
  logic         lane_sat;
  logic         out_free, accept, full, flush_req;

  vrequant_lane u_lane (
    .acc   (acc_i),
    .shift (shift_i),
    .res   (lane_byte),
    .sat   (lane_sat)
  );

  // Inputs stall while a flush waits for the output register, or when the
  // completing byte would have nowhere to go.
  assign out_free  = !valid_o || ready_i;
  assign ready_o   = !flush_pend && !(count == LANE_LAST && valid_o && !ready_i);
  assign accept    = valid_i && ready_o;
  assign full      = accept && count == LANE_LAST;
  assign flush_req = flush_i || flush_pend;
  assign cnt_nxt   = count + lane_cnt_t'(accept);

  always_comb begin
    pack_nxt = pack_q;
    if (accept) pack_nxt[count] = lane_byte;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count      <= '0;
      pack_q     <= '0;
      flush_pend <= 1'b0;
      word_o     <= '0;
      byte_en_o  <= '0;
      valid_o    <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      if (accept && lane_sat) sat_o <= 1'b1;
      else if (clr_sat_i)     sat_o <= 1'b0;

      if (valid_o && ready_i) valid_o <= 1'b0;

      if (full) begin
        word_o     <= pack_nxt;
        byte_en_o  <= 4'hF;
        valid_o    <= 1'b1;
        count      <= '0;
        pack_q     <= '0;
        flush_pend <= 1'b0;
      end else if (flush_req && out_free) begin
        count      <= '0;
        pack_q     <= '0;
        flush_pend <= 1'b0;
        if (cnt_nxt != '0) begin
          word_o    <= pack_nxt;
          byte_en_o <= lane_mask(cnt_nxt);
          valid_o   <= 1'b1;
        end
      end else begin
        count  <= cnt_nxt;
        pack_q <= pack_nxt;
        if (flush_i) flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vpack_requant.sv
// Bench for vpack_requant: directed cases plus random stress against a queue-based model.
module tb_vpack_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] acc;
  logic [4:0]  shift;
  logic        vin, fl, rdy, clr;
  logic        ready_o, valid_o, sat_o;
  logic [31:0] word_o;
  logic [3:0]  byte_en_o;

  vpack_requant dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .acc_i     (acc),
    .shift_i   (shift),
    .valid_i   (vin),
    .ready_o   (ready_o),
    .flush_i   (fl),
    .word_o    (word_o),
    .byte_en_o (byte_en_o),
    .valid_o   (valid_o),
    .ready_i   (rdy),
    .sat_o     (sat_o),
    .clr_sat_i (clr)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rounded value before clamping; -1 stands for "negative".
  function automatic longint ref_r(logic [31:0] a, int s);
    longint t;
    t = longint'($signed(a));
    if (s > 0) t = t + (longint'(1) << (s - 1));
    if (t < 0) return -1;
    return t >> s;
  endfunction

  function automatic int clamp8(longint r);
    if (r < 0)   return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  // Model: bytes gathered so far, words owed to the consumer in order,
  // a flush waiting on a busy output, and the sticky saturation flag.
  int          mb[$];
  logic [31:0] qw[$];
  logic [3:0]  qb[$];
  bit          mwait, msat, mon;
  bit          exp_rdy, free, wait0, acc_ok;
  longint      rr;
  logic [31:0] w;

  always @(negedge clk) begin
    if (mon) begin
      exp_rdy = !mwait && !(mb.size() == 3 && qw.size() > 0 && !rdy);
      chk("valid_o", 32'(valid_o), 32'(qw.size() > 0));
      if (qw.size() > 0) begin
        chk("word_o", word_o, qw[0]);
        chk("byte_en_o", 32'(byte_en_o), 32'(qb[0]));
      end
      chk("sat_o", 32'(sat_o), 32'(msat));
      chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    end
    if (!rst_n) begin
      mb.delete(); qw.delete(); qb.delete();
      mwait = 0; msat = 0; mon = 1;
    end else if (mon) begin
      free   = qw.size() == 0 || rdy;
      wait0  = mwait;
      acc_ok = vin && exp_rdy;
      if (qw.size() > 0 && rdy) begin
        void'(qw.pop_front());
        void'(qb.pop_front());
      end
      if (mwait && free) mwait = 0;
      rr = acc_ok ? ref_r(acc, int'(shift)) : 0;
      if (acc_ok && rr > 255) msat = 1;
      else if (clr)           msat = 0;
      if (acc_ok) begin
        mb.push_back(clamp8(rr));
        if (mb.size() == 4) begin
          w = 0;
          for (int k = 0; k < 4; k++) w |= 32'(mb[k]) << (8 * k);
          qw.push_back(w); qb.push_back(4'hF); mb.delete();
        end
      end
      if (fl && !wait0) begin
        if (mb.size() > 0) begin
          w = 0;
          for (int k = 0; k < mb.size(); k++) w |= 32'(mb[k]) << (8 * k);
          qw.push_back(w); qb.push_back(4'((1 << mb.size()) - 1)); mb.delete();
        end
        if (!free) mwait = 1;
      end
    end
  end

  task automatic cyc(bit v, logic [31:0] a, logic [4:0] s, bit f);
    vin = v; acc = a; shift = s; fl = f;
    @(posedge clk); #1;
    vin = 0; fl = 0;
  endtask

  initial begin
    mon = 0; rst_n = 0; vin = 0; fl = 0; rdy = 1; clr = 0; acc = 0; shift = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst valid_o", 32'(valid_o), 0);
    chk("rst word_o", word_o, 0);
    chk("rst byte_en_o", 32'(byte_en_o), 0);
    chk("rst sat_o", 32'(sat_o), 0);
    chk("rst ready_o", 32'(ready_o), 1);

    chk("model 0x180>>8", 32'(clamp8(ref_r(32'h180, 8))), 2);
    chk("model 0x17F>>8", 32'(clamp8(ref_r(32'h17F, 8))), 1);
    chk("model -5", 32'(clamp8(ref_r(32'hFFFF_FFFB, 0))), 0);
    chk("model max", 32'(clamp8(ref_r(32'h7FFF_FFFF, 0))), 255);

    // Basic pack
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 30, 0, 0);
    chk("pack pre valid", 32'(valid_o), 0);
    cyc(1, 40, 0, 0);
    chk("pack valid", 32'(valid_o), 1);
    chk("pack word", word_o, 32'h281E140A);
    chk("pack ben", 32'(byte_en_o), 32'hF);
    cyc(0, 0, 0, 0);

    // Rounding / clamping
    cyc(1, 32'h180, 8, 0); cyc(1, 32'h17F, 8, 0); cyc(1, 32'hFFFF_FFFB, 0, 0);
    chk("neg no sat", 32'(sat_o), 0);
    cyc(1, 32'h7FFF_FFFF, 0, 0);
    chk("round word", word_o, 32'hFF000102);
    chk("sat set", 32'(sat_o), 1);
    clr = 1; cyc(0, 0, 0, 0); clr = 0;
    chk("sat clr", 32'(sat_o), 0);

    // Back-pressure
    rdy = 0;
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0); cyc(1, 7, 0, 0);
    vin = 1; acc = 8; shift = 0; #1;
    chk("bp ready_o low", 32'(ready_o), 0);
    @(posedge clk); #1;
    chk("bp word stable", word_o, 32'h04030201);
    chk("bp ready still low", 32'(ready_o), 0);
    rdy = 1; #1;
    chk("bp ready_o up", 32'(ready_o), 1);
    @(posedge clk); #1; vin = 0;
    chk("bp word2", word_o, 32'h08070605);
    chk("bp valid b2b", 32'(valid_o), 1);
    @(posedge clk); #1;
    chk("bp drained", 32'(valid_o), 0);

    // Flush cases
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(0, 0, 0, 1);
    chk("flush word", word_o, 32'h00000201);
    chk("flush ben", 32'(byte_en_o), 32'h3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("flush empty", 32'(valid_o), 0);
    cyc(0, 0, 0, 0);
    chk("flush empty 2", 32'(valid_o), 0);
    cyc(1, 9, 0, 0); cyc(1, 10, 0, 0); cyc(1, 11, 0, 0); cyc(1, 12, 0, 1);
    chk("flush full word", word_o, 32'h0C0B0A09);
    chk("flush full ben", 32'(byte_en_o), 32'hF);
    cyc(0, 0, 0, 0);
    chk("flush single", 32'(valid_o), 0);

    // Reset mid-word
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0);
    rst_n = 0; cyc(0, 0, 0, 0); rst_n = 1;
    chk("midrst valid", 32'(valid_o), 0);
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0); cyc(1, 7, 0, 0);
    chk("midrst no partial", 32'(valid_o), 0);
    cyc(1, 8, 0, 0);
    chk("midrst word", word_o, 32'h08070605);
    cyc(0, 0, 0, 0);

    // Random stress
    repeat (3000) begin
      vin = ($urandom % 4) != 0;
      case ($urandom % 3)
        0: acc = $urandom % 300;
        1: acc = 32'hFFFF_FFFF - ($urandom % 1000);
        default: acc = $urandom;
      endcase
      shift = ($urandom % 2) ? 5'($urandom % 32) : 5'd0;
      rdy = ($urandom % 4) != 0;
      fl  = ($urandom % 20) == 0;
      clr = ($urandom % 30) == 0;
      @(posedge clk); #1;
    end
    vin = 0; fl = 0; clr = 0; rdy = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("final drained", 32'(qw.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
